// File: rtl/onehot_decoder_seq.sv
// ----------------------------------------------------------------------------
// onehot_decoder_seq
//
// Decodes one-hot words from a priority encoder into a binary index and
// buffers the results in a 2-entry FIFO with valid/ready handshakes on both
// sides. A word that is not exactly one-hot (no bit set, several bits set,
// or any X/Z bit) decodes to idx=0 with err=1.
//
// Optional feature: define ONEHOT_DECODER_ERR_CNT_EN to enable a saturating
// 8-bit count of accepted illegal words on err_cnt. When it is undefined,
// err_cnt stays on the port list and is tied to zero.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - in_y carries a word to decode
//   in_ready   - block can accept a word this cycle
//   in_y       - one-hot input word (WIDTH bits)
//   out_valid  - out_idx/out_err hold the FIFO head entry
//   out_ready  - consumer takes the head entry this cycle
//   out_idx    - binary index of the set bit (IDXW bits)
//   out_err    - head entry was not a legal one-hot word
//   err_cnt    - count of accepted illegal words (saturates at 255)
// ----------------------------------------------------------------------------
module onehot_decoder_seq #(
    parameter int WIDTH = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            err;
    } entry_t;

    state_t state;
    entry_t head;   // oldest entry, presented on the outputs
    entry_t tail;   // second entry, only meaningful in FULL
    entry_t dec;    // decode of the current input word

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Decoder. A bit counts as set only when it is a definite 1; any bit
    // that is neither 0 nor 1 marks the word illegal.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDXW-1:0] pos;
        logic            seen;
        logic            multi;
        logic            unknown;
        // NOTE: every variable gets a default before the loop, otherwise
        // paths that skip an assignment would infer latches.
        pos     = '0;
        seen    = 1'b0;
        multi   = 1'b0;
        unknown = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_y[i] === 1'b1) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
                pos  = IDXW'(i);
            end else if (in_y[i] !== 1'b0) begin
                unknown = 1'b1;
            end
        end
        dec.err = !seen || multi || unknown;
        dec.idx = dec.err ? '0 : pos;
    end

    // Reset holds in_ready low so no word is taken during the reset cycle.
    assign in_ready  = rst_n && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Outputs are read from registers only; zeroed when nothing is held.
    assign out_idx = out_valid ? head.idx : '0;
    assign out_err = out_valid ? head.err : 1'b0;

    // ------------------------------------------------------------------
    // FIFO control. head/tail are data only and need no reset: they are
    // masked by out_valid until written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= dec;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= dec;          // old head leaves, new word replaces it
                    end else if (push) begin
                        tail  <= dec;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef ONEHOT_DECODER_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (push && dec.err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// ----------------------------------------------------------------------------
// tb_onehot_decoder_seq
//
// Scoreboard bench for onehot_decoder_seq. The driver pushes the
// hand-computed expected {idx, err} into a queue when a word is accepted;
// a monitor on the falling edge pops and compares whenever the DUT is about
// to hand over an entry (out_valid && out_ready). Directed checks cover
// reset, latency, back-pressure, hold stability and err_cnt.
// ----------------------------------------------------------------------------
module tb_onehot_decoder_seq;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_err;
    logic [7:0]       err_cnt;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef ONEHOT_DECODER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    onehot_decoder_seq #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a word and wait (bounded) for it to be accepted; the expected
    // decode enters the scoreboard on the accepting edge.
    task automatic send(input logic [WIDTH-1:0] y, input logic [IDXW-1:0] e_idx,
                        input logic e_err, input int max_wait);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_y     = y;
        for (int c = 0; c < max_wait && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{idx: e_idx, err: e_err});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_y     = '0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted within %0d cycles", y, max_wait);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare the head against the scoreboard on each transfer,
    // and check that empty outputs read as zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: DUT idx=%0d err=%0b with nothing expected",
                             out_idx, out_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mon_idx", 32'(out_idx), 32'(e.idx));
                    check("mon_err", 32'(out_err), 32'(e.err));
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero", {30'd0, out_err, |out_idx}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;

        // ---- Reset state ----
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- Single legal word, one-cycle latency ----
        send(8'b0000_0100, 3'd2, 1'b0, 10);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_idx", 32'(out_idx), 32'd2);
        check("lat_out_err", 32'(out_err), 32'd0);
        idle(2);

        // ---- Illegal words ----
        send(8'b0000_0000, 3'd0, 1'b1, 10);
        send(8'b1000_0001, 3'd0, 1'b1, 10);
        send(8'bxxxx_xxxx, 3'd0, 1'b1, 10);
        idle(3);
        check("err_cnt_three", 32'(err_cnt), CNT_EN ? 32'd3 : 32'd0);

        // ---- Back-pressure: fill, hold third word, drain in order ----
        out_ready = 1'b0;
        send(8'h01, 3'd0, 1'b0, 10);
        send(8'h80, 3'd7, 1'b0, 10);
        fork
            send(8'h10, 3'd4, 1'b0, 20);
            begin
                @(negedge clk);
                check("full_in_ready", 32'(in_ready), 32'd0);
                check("full_out_valid", 32'(out_valid), 32'd1);
                check("full_head_idx", 32'(out_idx), 32'd0);
                @(negedge clk);
                check("hold_in_ready", 32'(in_ready), 32'd0);
                check("hold_head_idx", 32'(out_idx), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                // Still FULL: a pop does not open a pass-through.
                check("full_no_passthru", 32'(in_ready), 32'd0);
            end
        join
        idle(4);
        check("drained_sb_empty", 32'(sb.size()), 32'd0);

        // ---- ONE with simultaneous push and pop ----
        out_ready = 1'b0;
        send(8'h08, 3'd3, 1'b0, 10);
        @(negedge clk);
        check("one_head_idx3", 32'(out_idx), 32'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h20, 3'd5, 1'b0, 10);
        @(negedge clk);
        check("pp_out_valid", 32'(out_valid), 32'd1);
        check("pp_head_idx5", 32'(out_idx), 32'd5);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        idle(2);

        // ---- Reset while FULL, word presented during reset ----
        out_ready = 1'b0;
        send(8'h03, 3'd0, 1'b1, 10);
        send(8'h40, 3'd6, 1'b0, 10);
        @(negedge clk);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_y     = 8'h01;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_y     = '0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- Saturation of err_cnt ----
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'h00, 3'd0, 1'b1, 10);
        end
        idle(3);
        check("err_cnt_saturate", 32'(err_cnt), CNT_EN ? 32'd255 : 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
